// File: rtl/imem_resp_if.sv
// Fetch-port and system-bus read-channel bundles used by the instruction-fetch
// responder.
interface imem_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_rdata;
  logic [1:0]        imem_bad;
  logic              imem_busy;

  modport master (output imem_req, imem_addr, input imem_rdata, imem_bad, imem_busy);
  modport slave  (input imem_req, imem_addr, output imem_rdata, imem_bad, imem_busy);
endinterface

interface membus_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              m_req;
  logic [ADDR_W-1:0] m_addr;
  logic              m_gnt;
  logic              m_rvalid;
  logic [DATA_W-1:0] m_rdata;
  logic              m_rerr;

  modport master (output m_req, m_addr, input m_gnt, m_rvalid, m_rdata, m_rerr);
  modport slave  (input m_req, m_addr, output m_gnt, m_rvalid, m_rdata, m_rerr);
endinterface

// File: rtl/imem_resp.sv
// Instruction-fetch responder: one-word fetch buffer, executable-range check and
// a single-outstanding bus read channel.
module imem_resp #(
  parameter int                ADDR_W     = 32,
  parameter int                DATA_W     = 32,
  parameter logic [ADDR_W-1:0] EXEC_BASE  = 32'h0000_0000,
  parameter logic [ADDR_W-1:0] EXEC_LIMIT = 32'h7fff_ffff
) (
  input  logic     clk,
  input  logic     rstn,
  input  logic     ic_flush,
  input  logic     kill,
  imem_if.slave    ifu,
  membus_if.master bus
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, DRAIN} state_t;

  state_t            state;
  logic              busy_q;
  logic [DATA_W-1:0] rdata_q;
  logic [1:0]        bad_q;
  logic              m_req_q;
  logic [ADDR_W-1:0] m_addr_q;
  logic              buf_valid;
  logic [ADDR_W-1:0] buf_tag;
  logic [DATA_W-1:0] buf_data;

  logic              accept;
  logic              below_base;
  logic              above_limit;
  logic              hit;
  logic [ADDR_W-1:0] waddr;

  assign waddr  = {ifu.imem_addr[ADDR_W-1:2], 2'b00};
  assign accept = ifu.imem_req & ~busy_q & ~kill;
  assign hit    = buf_valid & (buf_tag == waddr) & ~ic_flush;

  // Bounds at the ends of the address space make one side of the check
  // vacuous; resolve that at elaboration instead of comparing against a constant.
  if (EXEC_BASE == '0) begin : g_no_base
    assign below_base = 1'b0;
  end else begin : g_base
    assign below_base = ifu.imem_addr < EXEC_BASE;
  end

  if (EXEC_LIMIT == '1) begin : g_no_limit
    assign above_limit = 1'b0;
  end else begin : g_limit
    assign above_limit = ifu.imem_addr > EXEC_LIMIT;
  end

  // NOTE: state is updated with <= so every register samples pre-edge values;
  // blocking assignments here would create order-dependent simulation races.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      busy_q    <= 1'b0;
      rdata_q   <= '0;
      bad_q     <= 2'b00;
      m_req_q   <= 1'b0;
      m_addr_q  <= '0;
      // NOTE: only buf_valid must be reset for correctness; tag and data are
      // reset as well so nothing downstream ever observes X after power-up.
      buf_valid <= 1'b0;
      buf_tag   <= '0;
      buf_data  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            if (below_base || above_limit) begin
              rdata_q <= '0;
              bad_q   <= 2'b10;
            end else if (hit) begin
              rdata_q <= buf_data;
              bad_q   <= 2'b00;
            end else begin
              m_addr_q <= waddr;
              m_req_q  <= 1'b1;
              busy_q   <= 1'b1;
              state    <= ADDR;
            end
          end
        end
        ADDR: begin
          if (bus.m_gnt) begin
            m_req_q <= 1'b0;
            state   <= kill ? DRAIN : DATA;
          end else if (kill) begin
            m_req_q <= 1'b0;
            busy_q  <= 1'b0;
            state   <= IDLE;
          end
        end
        DATA: begin
          if (bus.m_rvalid) begin
            if (!kill) begin
              rdata_q <= bus.m_rdata;
              bad_q   <= {bus.m_rerr, 1'b0};
            end
            // A redirect discards the response but the word is still good to cache.
            if (!bus.m_rerr) begin
              buf_valid <= 1'b1;
              buf_tag   <= m_addr_q;
              buf_data  <= bus.m_rdata;
            end
            busy_q <= 1'b0;
            state  <= IDLE;
          end else if (kill) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (bus.m_rvalid) begin
            busy_q <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      // Last assignment wins: a flush overrides a fill landing in the same cycle.
      if (ic_flush) buf_valid <= 1'b0;
    end
  end

  assign ifu.imem_busy  = busy_q;
  assign ifu.imem_rdata = rdata_q;
  assign ifu.imem_bad   = bad_q;
  assign bus.m_req      = m_req_q;
  assign bus.m_addr     = m_addr_q;

endmodule
